// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 2-read-port register file between two requesters,
// with a registered, ID-tagged response. Optional: RF_X0_ZERO_EN forces address-0 operands to zero.
module regfile_read_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_rs1,
    input  logic [AW-1:0] req0_rs2,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_rs1,
    input  logic [AW-1:0] req1_rs2,
    output logic          req1_ready,
    output logic [AW-1:0] rf_rs1,
    output logic [AW-1:0] rf_rs2,
    input  logic [DW-1:0] rf_rs1_data,
    input  logic [DW-1:0] rf_rs2_data,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_rs1_data,
    output logic [DW-1:0] rsp_rs2_data,
    input  logic          rsp_ready
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic          id_q, id_d;
    logic [DW-1:0] d1_q, d1_d, d2_q, d2_d;
    logic          can_accept, gnt0, gnt1;
    logic [DW-1:0] rs1_val, rs2_val;

    // Reset gates acceptance so no request is consumed while reset is sampled.
    always_comb begin
        can_accept = !reset && ((state_q == IDLE) || rsp_ready);
        gnt0       = can_accept && req0_valid && (!req1_valid || !rr_q);
        gnt1       = can_accept && req1_valid && (!req0_valid ||  rr_q);
        rf_rs1     = '0;
        rf_rs2     = '0;
        if (gnt0) begin
            rf_rs1 = req0_rs1;
            rf_rs2 = req0_rs2;
        end else if (gnt1) begin
            rf_rs1 = req1_rs1;
            rf_rs2 = req1_rs2;
        end
`ifdef RF_X0_ZERO_EN
        rs1_val = (rf_rs1 == '0) ? '0 : rf_rs1_data;
        rs2_val = (rf_rs2 == '0) ? '0 : rf_rs2_data;
`else
        rs1_val = rf_rs1_data;
        rs2_val = rf_rs2_data;
`endif
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        if (gnt0 || gnt1) begin
            state_d = RESP;
            rr_d    = ~gnt1;
            id_d    = gnt1;
            d1_d    = rs1_val;
            d2_d    = rs2_val;
        end else if ((state_q == RESP) && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = id_q;
    assign rsp_rs1_data = d1_q;
    assign rsp_rs2_data = d2_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: a behavioural register file drives read data,
// expected responses are queued at grant time and compared when the response appears.
module tb_regfile_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_rs1, req0_rs2, req1_rs1, req1_rs2, rf_rs1, rf_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data, rsp_rs1_data, rsp_rs2_data;
    logic        rsp_valid, rsp_id, rsp_ready;

    int          tests = 0;
    int          fails = 0;
    logic [64:0] exp_q[$];
    logic [64:0] e, held;

    always #5 clk = ~clk;

    assign rf_rs1_data = 32'h1000_0000 + {27'b0, rf_rs1};
    assign rf_rs2_data = 32'h1000_0000 + {27'b0, rf_rs2};

    regfile_read_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_ready(req1_ready),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rs1_data(rsp_rs1_data),
        .rsp_rs2_data(rsp_rs2_data), .rsp_ready(rsp_ready)
    );

    function automatic logic [31:0] exp_val(input logic [4:0] a);
`ifdef RF_X0_ZERO_EN
        if (a == 5'd0) return 32'h0;
`endif
        return 32'h1000_0000 + {27'b0, a};
    endfunction

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_rs1 = 5'd4; req0_rs2 = 5'd7;
        req1_valid = 1'b0; req1_rs1 = 5'd0; req1_rs2 = 5'd0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            tests++;
            if ({req0_ready, req1_ready, rf_rs1, rf_rs2, rsp_valid} !== 13'b0) begin
                fails++;
                $display("FAIL reset_comb c=%0d got r0=%b r1=%b rs1=%0d rs2=%0d v=%b want all 0",
                         c, req0_ready, req1_ready, rf_rs1, rf_rs2, rsp_valid);
            end
        end
        reset = 1'b0; req0_valid = 1'b0;
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_rs1_data, rsp_rs2_data} !== 66'b0) begin
            fails++;
            $display("FAIL reset_state got v=%b id=%b d1=%h d2=%h want 0", rsp_valid, rsp_id,
                     rsp_rs1_data, rsp_rs2_data);
        end
    endtask

    // Both requesters valid for 4 cycles right after reset: pointer starts at 0.
    task automatic test_rr_back_to_back();
        logic g;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            req0_valid = (c < 4); req0_rs1 = 5'd1; req0_rs2 = 5'd2;
            req1_valid = (c < 4); req1_rs1 = 5'd5; req1_rs2 = 5'd6;
            #1;
            tests++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (rsp_valid !== 1'b1 || {rsp_id, rsp_rs1_data, rsp_rs2_data} !== e) begin
                    fails++;
                    $display("FAIL rr_rsp c=%0d got v=%b %h want v=1 %h", c, rsp_valid,
                             {rsp_id, rsp_rs1_data, rsp_rs2_data}, e);
                end
            end else if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL rr_idle c=%0d got v=%b want 0", c, rsp_valid);
            end
            if (c < 4) begin
                g = (c % 2) == 1;
                tests++;
                if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01) ||
                    {rf_rs1, rf_rs2} !== (g ? {5'd5, 5'd6} : {5'd1, 5'd2})) begin
                    fails++;
                    $display("FAIL rr_grant c=%0d got r1r0=%b%b rs=%0d/%0d want id %0d", c,
                             req1_ready, req0_ready, rf_rs1, rf_rs2, g);
                end
                exp_q.push_back({g, exp_val(g ? 5'd5 : 5'd1), exp_val(g ? 5'd6 : 5'd2)});
            end
        end
    endtask

    // Single requester 0 read; idle cycle follows.
    task automatic test_single(input logic [4:0] a1, input logic [4:0] a2);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req1_valid = 1'b0;
            req0_valid = (c == 0); req0_rs1 = a1; req0_rs2 = a2;
            #1;
            tests++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (rsp_valid !== 1'b1 || {rsp_id, rsp_rs1_data, rsp_rs2_data} !== e) begin
                    fails++;
                    $display("FAIL single_rsp a=%0d/%0d got v=%b %h want v=1 %h", a1, a2,
                             rsp_valid, {rsp_id, rsp_rs1_data, rsp_rs2_data}, e);
                end
            end else if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL single_idle c=%0d got v=%b want 0", c, rsp_valid);
            end
            if (c == 0) begin
                tests++;
                if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || {rf_rs1, rf_rs2} !== {a1, a2}) begin
                    fails++;
                    $display("FAIL single_grant got r0=%b r1=%b rs=%0d/%0d want 1 0 %0d/%0d",
                             req0_ready, req1_ready, rf_rs1, rf_rs2, a1, a2);
                end
                exp_q.push_back({1'b0, exp_val(a1), exp_val(a2)});
            end
        end
    endtask

    // Consumer stalls 3 cycles with req1 pending; response must hold.
    task automatic test_stall();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            req0_valid = (c == 0); req0_rs1 = 5'd2; req0_rs2 = 5'd2;
            req1_valid = (c >= 1 && c <= 4); req1_rs1 = 5'd3; req1_rs2 = 5'd3;
            rsp_ready  = !(c >= 1 && c <= 3);
            #1;
            tests++;
            if (c >= 2 && c <= 4) begin
                if (rsp_valid !== 1'b1 || {rsp_id, rsp_rs1_data, rsp_rs2_data} !== held) begin
                    fails++;
                    $display("FAIL stall_hold c=%0d got v=%b %h want v=1 %h", c, rsp_valid,
                             {rsp_id, rsp_rs1_data, rsp_rs2_data}, held);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); held = e;
                if (rsp_valid !== 1'b1 || {rsp_id, rsp_rs1_data, rsp_rs2_data} !== e) begin
                    fails++;
                    $display("FAIL stall_rsp c=%0d got v=%b %h want v=1 %h", c, rsp_valid,
                             {rsp_id, rsp_rs1_data, rsp_rs2_data}, e);
                end
            end else if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL stall_idle c=%0d got v=%b want 0", c, rsp_valid);
            end
            if (c >= 1 && c <= 3) begin
                tests++;
                if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_ready c=%0d got r1=%b r0=%b want 0 0", c, req1_ready, req0_ready);
                end
            end
            if (c == 0 || c == 4) begin
                tests++;
                if ((c == 0 && req0_ready !== 1'b1) || (c == 4 && (req1_ready !== 1'b1 ||
                    {rf_rs1, rf_rs2} !== {5'd3, 5'd3}))) begin
                    fails++;
                    $display("FAIL stall_grant c=%0d got r0=%b r1=%b rs=%0d/%0d want grant",
                             c, req0_ready, req1_ready, rf_rs1, rf_rs2);
                end
                exp_q.push_back(c == 0 ? {1'b0, exp_val(5'd2), exp_val(5'd2)}
                                       : {1'b1, exp_val(5'd3), exp_val(5'd3)});
            end
        end
        rsp_ready = 1'b1;
    endtask

    // Reset while a stalled response is held; reset beats a same-cycle grant.
    task automatic test_reset_mid();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            reset      = (c == 2);
            rsp_ready  = !(c == 1 || c == 2);
            req0_valid = (c == 0 || c == 2 || c == 3); req0_rs1 = 5'd1; req0_rs2 = 5'd8;
            req1_valid = (c == 2 || c == 3); req1_rs1 = 5'd5; req1_rs2 = 5'd6;
            #1;
            tests++;
            if (c == 3) begin
                if ({rsp_valid, rsp_id, rsp_rs1_data, rsp_rs2_data} !== 66'b0) begin
                    fails++;
                    $display("FAIL midreset_clear got v=%b d1=%h d2=%h want 0", rsp_valid,
                             rsp_rs1_data, rsp_rs2_data);
                end
            end else if (c == 2) begin
                if ({req0_ready, req1_ready, rf_rs1, rf_rs2} !== 12'b0 || rsp_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL midreset_prio got r0=%b r1=%b rs=%0d/%0d v=%b want 0 0 0/0 1",
                             req0_ready, req1_ready, rf_rs1, rf_rs2, rsp_valid);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (rsp_valid !== 1'b1 || {rsp_id, rsp_rs1_data, rsp_rs2_data} !== e) begin
                    fails++;
                    $display("FAIL midreset_rsp c=%0d got v=%b %h want v=1 %h", c, rsp_valid,
                             {rsp_id, rsp_rs1_data, rsp_rs2_data}, e);
                end
            end else if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL midreset_idle c=%0d got v=%b want 0", c, rsp_valid);
            end
            if (c == 0 || c == 3) begin
                tests++;
                if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL midreset_grant c=%0d got r0=%b r1=%b want 1 0", c, req0_ready, req1_ready);
                end
                exp_q.push_back({1'b0, exp_val(5'd1), exp_val(5'd8)});
            end
        end
        reset = 1'b0; rsp_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rr_back_to_back();
        test_single(5'd4, 5'd7);
        test_stall();
        test_single(5'd0, 5'd9);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got no completion want summary");
        $fatal(1, "timeout");
    end

endmodule
